// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions, ALUOp encodings, bubble value.
package pipe_pkg;

  localparam int CTRL_W = 9;

  // Control word packing: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
  localparam int CTRL_REGWRITE  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_MEMTOREG  = 5;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_LUI   = 3'b110,
    ALUOP_XOR   = 3'b111
  } aluop_e;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the instruction in EX and the one in ID.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             i_ex_valid,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_hazard
);

  logic w_ex_is_load;
  logic w_src_match;

  // $0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rt != '0);
  assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
  assign o_hazard     = w_ex_is_load & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory-stall hold.
// Optional hazard-stall counter output enabled by defining IDEX_STALL_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              Flush,
  input  logic              MemStall,
  output logic              IDEX_Valid,
  output logic [REG_W-1:0]  IDEX_Rs,
  output logic [REG_W-1:0]  IDEX_Rt,
  output logic [REG_W-1:0]  IDEX_Rd,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic              PCWrite,
  output logic              IFID_Write
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  logic              r_valid;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [CTRL_W-1:0] r_ctrl;

  logic w_hazard;
  logic w_hazard_bubble;
  logic w_load_bubble;
  logic w_front_hold;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .i_ex_valid   (r_valid),
    .i_ex_memread (ctrl_memread(r_ctrl)),
    .i_ex_rt      (r_rt),
    .i_id_valid   (ID_Valid),
    .i_id_rs      (ID_Rs),
    .i_id_rt      (ID_Rt),
    .o_hazard     (w_hazard)
  );

  // Flush outranks the hazard: the squashed ID instruction must not be retried.
  assign w_hazard_bubble = ~MemStall & ~Flush & w_hazard;
  assign w_load_bubble   = Flush | w_hazard;
  assign w_front_hold    = MemStall | w_hazard_bubble;

  assign PCWrite    = reset | ~w_front_hold;
  assign IFID_Write = reset | ~w_front_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_ctrl  <= BUBBLE_CTRL;
    end else if (!MemStall) begin
      if (w_load_bubble) begin
        r_valid <= 1'b0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_rd    <= '0;
        r_rd1   <= '0;
        r_rd2   <= '0;
        r_imm   <= '0;
        r_ctrl  <= BUBBLE_CTRL;
      end else begin
        r_valid <= ID_Valid;
        r_rs    <= ID_Rs;
        r_rt    <= ID_Rt;
        r_rd    <= ID_Rd;
        r_rd1   <= ID_ReadData1;
        r_rd2   <= ID_ReadData2;
        r_imm   <= ID_Imm;
        r_ctrl  <= ID_Valid ? ID_Ctrl : BUBBLE_CTRL;
      end
    end
  end

  assign IDEX_Valid     = r_valid;
  assign IDEX_Rs        = r_rs;
  assign IDEX_Rt        = r_rt;
  assign IDEX_Rd        = r_rd;
  assign IDEX_ReadData1 = r_rd1;
  assign IDEX_ReadData2 = r_rd2;
  assign IDEX_Imm       = r_imm;
  assign IDEX_Ctrl      = r_ctrl;

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_hazard_bubble && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a monitor checks them.
// Also checks StallCount when IDEX_STALL_CNT_EN is defined.
module tb_id_ex_stage;

  // lw : RegWrite=1 MemRead=1 MemWrite=0 MemtoReg=1 ALUSrc=1 RegDst=0 ALUOp=000 -> 1_1011_0000
  localparam logic [8:0] C_LW  = 9'h1B0;
  // add: RegWrite=1 MemRead=0 MemWrite=0 MemtoReg=0 ALUSrc=0 RegDst=1 ALUOp=010 -> 1_0000_1010
  localparam logic [8:0] C_ADD = 9'h10A;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [8:0]  ctrl;
  } fields_t;

  typedef enum int {K_CAP, K_BUB, K_HOLD} kind_e;

  typedef struct {
    fields_t    regs;
    logic       pcw;
    logic [15:0] cnt;
    string      name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ID_Valid;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [8:0]  ID_Ctrl;
  logic        Flush, MemStall;
  logic        IDEX_Valid;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic [8:0]  IDEX_Ctrl;
  logic        PCWrite, IFID_Write;
`ifdef IDEX_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Valid       (ID_Valid),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_Rd          (ID_Rd),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .ID_Imm         (ID_Imm),
    .ID_Ctrl        (ID_Ctrl),
    .Flush          (Flush),
    .MemStall       (MemStall),
    .IDEX_Valid     (IDEX_Valid),
    .IDEX_Rs        (IDEX_Rs),
    .IDEX_Rt        (IDEX_Rt),
    .IDEX_Rd        (IDEX_Rd),
    .IDEX_ReadData1 (IDEX_ReadData1),
    .IDEX_ReadData2 (IDEX_ReadData2),
    .IDEX_Imm       (IDEX_Imm),
    .IDEX_Ctrl      (IDEX_Ctrl),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write)
`ifdef IDEX_STALL_CNT_EN
    ,
    .StallCount     (StallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t    exp_q[$];
  fields_t last_exp;
  logic [15:0] exp_cnt;
  int      n_cmp;
  int      n_bad;
  int      n_txn;

  function automatic fields_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [8:0] ctrl);
    fields_t f;
    f.v = v; f.rs = rs; f.rt = rt; f.rd = rd;
    f.d1 = d1; f.d2 = d2; f.imm = imm; f.ctrl = ctrl;
    return f;
  endfunction

  // Drive one cycle of ID inputs at the falling edge and queue what EX must show after the next rise.
  task automatic step(input fields_t f, input logic fl, input logic ms, input logic rst,
                      input kind_e kind, input logic pcw, input string name);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    ID_Valid     = f.v;
    ID_Rs        = f.rs;
    ID_Rt        = f.rt;
    ID_Rd        = f.rd;
    ID_ReadData1 = f.d1;
    ID_ReadData2 = f.d2;
    ID_Imm       = f.imm;
    ID_Ctrl      = f.ctrl;
    Flush        = fl;
    MemStall     = ms;
    case (kind)
      K_CAP: begin
        e.regs = f;
        if (!f.v) e.regs.ctrl = 9'h000;
      end
      K_BUB:   e.regs = '0;
      default: e.regs = last_exp;
    endcase
    if (rst) e.regs = '0;
    last_exp = e.regs;
    if (rst) exp_cnt = 16'd0;
    else if (kind == K_BUB && !pcw && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.pcw  = rst ? 1'b1 : pcw;
    e.cnt  = exp_cnt;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: samples the combinational stall outputs mid-cycle, the registers just after the edge.
  initial begin : monitor
    logic    pcw_s, ifw_s;
    fields_t got;
    exp_t    e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        pcw_s = PCWrite;
        ifw_s = IFID_Write;
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        got = {IDEX_Valid, IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_ReadData1, IDEX_ReadData2,
               IDEX_Imm, IDEX_Ctrl};
        n_txn++;
        n_cmp++;
        if (got !== e.regs) begin
          n_bad++;
          $display("FAIL %s idex: got v=%0b rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h ctrl=%h want v=%0b rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h ctrl=%h",
                   e.name, got.v, got.rs, got.rt, got.rd, got.d1, got.d2, got.imm, got.ctrl,
                   e.regs.v, e.regs.rs, e.regs.rt, e.regs.rd, e.regs.d1, e.regs.d2,
                   e.regs.imm, e.regs.ctrl);
        end
        n_cmp++;
        if (pcw_s !== e.pcw || ifw_s !== e.pcw) begin
          n_bad++;
          $display("FAIL %s stall: got PCWrite=%0b IFID_Write=%0b want both %0b",
                   e.name, pcw_s, ifw_s, e.pcw);
        end
`ifdef IDEX_STALL_CNT_EN
        n_cmp++;
        if (StallCount !== e.cnt) begin
          n_bad++;
          $display("FAIL %s count: got %0d want %0d", e.name, StallCount, e.cnt);
        end
`endif
        $display("txn %0d %s: v=%0b rs=%0d rt=%0d ctrl=%h pcw=%0b", n_txn, e.name,
                 got.v, got.rs, got.rt, got.ctrl, pcw_s);
      end
    end
  end

  initial begin : driver
    fields_t z;
    int      wait_cyc;
    z = '0;
    n_cmp = 0; n_bad = 0; n_txn = 0;
    exp_cnt = 16'd0;
    last_exp = '0;
    reset = 1'b1;
    ID_Valid = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;
    ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0; ID_Ctrl = '0;
    Flush = 1'b0; MemStall = 1'b0;

    // Reset with random ID inputs and a stall request: everything stays zero, front end enabled.
    step(mk(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            9'($urandom)), 1'b0, 1'b1, 1'b1, K_BUB, 1'b1, "reset_a");
    step(mk(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            9'($urandom)), 1'b1, 1'b0, 1'b1, K_BUB, 1'b1, "reset_b");

    // Load-use: lw $8 then add reading $8 -> one bubble, then the add is captured.
    step(mk(1, 9, 8, 0, 32'd100, 32'd0, 32'd4, C_LW), 0, 0, 0, K_CAP, 1, "lw_r8");
    step(mk(1, 8, 9, 10, 32'd11, 32'd22, 32'd0, C_ADD), 0, 0, 0, K_BUB, 0, "add_hazard");
    step(mk(1, 8, 9, 10, 32'd11, 32'd22, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "add_retry");

    // $0 dependency never stalls.
    step(mk(1, 1, 0, 0, 32'd7, 32'd0, 32'd8, C_LW), 0, 0, 0, K_CAP, 1, "lw_r0");
    step(mk(1, 0, 0, 5, 32'd0, 32'd0, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "read_r0");

    // Back-to-back dependent loads each stall once; second source (Rt) also matches.
    step(mk(1, 1, 8, 0, 32'h1000, 32'd0, 32'd0, C_LW), 0, 0, 0, K_CAP, 1, "lw1");
    step(mk(1, 8, 9, 0, 32'h2000, 32'd0, 32'd4, C_LW), 0, 0, 0, K_BUB, 0, "lw2_hazard");
    step(mk(1, 8, 9, 0, 32'h2000, 32'd0, 32'd4, C_LW), 0, 0, 0, K_CAP, 1, "lw2_retry");
    step(mk(1, 2, 9, 11, 32'd5, 32'd6, 32'd0, C_ADD), 0, 0, 0, K_BUB, 0, "rt_hazard");
    step(mk(1, 2, 9, 11, 32'd5, 32'd6, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "rt_retry");

    // Flush in the same cycle as a hazard: bubble, front end keeps running, no count.
    step(mk(1, 1, 4, 0, 32'd3, 32'd0, 32'd12, C_LW), 0, 0, 0, K_CAP, 1, "lw_r4");
    step(mk(1, 2, 4, 12, 32'd1, 32'd2, 32'd0, C_ADD), 1, 0, 0, K_BUB, 1, "flush_hazard");

    // MemStall holds a captured add for three cycles, even with Flush asserted.
    step(mk(1, 1, 2, 3, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0010, C_ADD), 0, 0, 0,
         K_CAP, 1, "add_r3");
    step(mk(1, 7, 6, 5, 32'h1, 32'h2, 32'h3, C_LW), 0, 1, 0, K_HOLD, 0, "memstall_1");
    step(mk(0, 4, 4, 4, 32'h4, 32'h5, 32'h6, C_ADD), 1, 1, 0, K_HOLD, 0, "memstall_2");
    step(mk(1, 3, 3, 3, 32'h7, 32'h8, 32'h9, C_ADD), 0, 1, 0, K_HOLD, 0, "memstall_3");
    step(mk(1, 5, 6, 7, 32'h11, 32'h22, 32'h33, C_ADD), 0, 0, 0, K_CAP, 1, "after_stall");

    // MemStall over a pending hazard: hold first, then exactly one bubble.
    step(mk(1, 1, 6, 0, 32'd40, 32'd0, 32'd0, C_LW), 0, 0, 0, K_CAP, 1, "lw_r6");
    step(mk(1, 6, 2, 13, 32'd0, 32'd9, 32'd0, C_ADD), 0, 1, 0, K_HOLD, 0, "stall_on_hazard");
    step(mk(1, 6, 2, 13, 32'd0, 32'd9, 32'd0, C_ADD), 0, 0, 0, K_BUB, 0, "hazard_after");
    step(mk(1, 6, 2, 13, 32'd0, 32'd9, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "hazard_retry");

    // Invalid ID slot does not stall and is captured with control cleared.
    step(mk(1, 1, 7, 0, 32'd50, 32'd0, 32'd0, C_LW), 0, 0, 0, K_CAP, 1, "lw_r7");
    step(mk(0, 7, 7, 14, 32'd1, 32'd2, 32'd3, C_ADD), 0, 0, 0, K_CAP, 1, "invalid_id");

    // Reset asserted mid-stall: outputs clear immediately, no residual stall afterwards.
    step(mk(1, 1, 8, 0, 32'd60, 32'd0, 32'd0, C_LW), 0, 0, 0, K_CAP, 1, "lw_r8_b");
    step(mk(1, 8, 1, 15, 32'd0, 32'd0, 32'd0, C_ADD), 0, 0, 1, K_BUB, 1, "reset_mid");
    #1;
    n_cmp++;
    if (IDEX_Valid !== 1'b0 || IDEX_Ctrl !== 9'h000 || IDEX_Rt !== 5'd0 || PCWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got v=%0b ctrl=%h rt=%0d pcw=%0b want v=0 ctrl=000 rt=0 pcw=1",
               IDEX_Valid, IDEX_Ctrl, IDEX_Rt, PCWrite);
    end
    step(mk(1, 8, 1, 15, 32'd5, 32'd6, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "post_reset");
    step(mk(1, 2, 3, 16, 32'd1, 32'd1, 32'd0, C_ADD), 0, 0, 0, K_CAP, 1, "post_reset_2");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

`ifdef IDEX_STALL_CNT_EN
    // Pin a load in EX so every edge is a hazard bubble until the counter saturates.
    @(negedge clk);
    ID_Valid = 1'b1; ID_Rs = 5'd8; ID_Rt = 5'd1; ID_Ctrl = C_ADD;
    Flush = 1'b0; MemStall = 1'b0;
    force dut.r_valid = 1'b1;
    force dut.r_ctrl  = C_LW;
    force dut.r_rt    = 5'd8;
    repeat (65540) @(negedge clk);
    n_cmp++;
    if (StallCount !== 16'hFFFF || PCWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate: got count=%h pcw=%0b want count=ffff pcw=0", StallCount, PCWrite);
    end
    release dut.r_valid;
    release dut.r_ctrl;
    release dut.r_rt;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded operands, register indices and control bits from ID and presents them to EX.
- IDEX_Rs and IDEX_Rt feed the forwarding unit, which selects EX operand sources.
- Inserts bubbles on load-use hazards, squashes on branch flush, and holds on downstream memory stalls.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ID_Valid  in  1  ID stage holds a real instruction
- ID_Rs  in  REG_W  source register 1 index
- ID_Rt  in  REG_W  source register 2 index
- ID_Rd  in  REG_W  destination index (R-type)
- ID_ReadData1  in  DATA_W  register file port 1
- ID_ReadData2  in  DATA_W  register file port 2
- ID_Imm  in  DATA_W  sign-extended immediate
- ID_Ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
- Flush  in  1  branch/jump taken in EX; squash ID instruction
- MemStall  in  1  downstream memory busy; freeze whole front end
- IDEX_Valid  out  1  EX instruction is real
- IDEX_Rs  out  REG_W  to forwarding unit
- IDEX_Rt  out  REG_W  to forwarding unit
- IDEX_Rd  out  REG_W  to EX destination mux
- IDEX_ReadData1  out  DATA_W  EX operand A
- IDEX_ReadData2  out  DATA_W  EX operand B
- IDEX_Imm  out  DATA_W  EX immediate
- IDEX_Ctrl  out  9  control bits, same packing as ID_Ctrl
- PCWrite  out  1  0 = hold PC
- IFID_Write  out  1  0 = hold IF/ID register

Behaviour:
- Reset (async, immediate): every registered output = 0. IDEX_Ctrl = 0 makes the stage a bubble. PCWrite and IFID_Write are combinational and evaluate to 1 while reset is asserted.
- Hazard detection (combinational):
  - hazard = IDEX_Valid & IDEX_Ctrl.MemRead & (IDEX_Rt != 0) & ID_Valid & ((IDEX_Rt == ID_Rs) | (IDEX_Rt == ID_Rt)).
  - Using ID_Rt unconditionally is allowed (conservative).
- Per-edge update priority: reset > MemStall > Flush > hazard > capture.
  - MemStall: all registers hold. PCWrite = IFID_Write = 0.
  - Flush (no MemStall): load a bubble (IDEX_Valid = 0, IDEX_Ctrl = 0; index and data fields zeroed). PCWrite = IFID_Write = 1. Hazard is ignored.
  - Hazard (no MemStall, no Flush): load a bubble. PCWrite = IFID_Write = 0 so the ID instruction is retried next cycle.
  - Capture: register all ID_* fields. IDEX_Valid = ID_Valid. IDEX_Ctrl = ID_Valid ? ID_Ctrl : 0.
- Latency: 1 cycle from ID inputs to IDEX outputs.
- A load-use stall lasts exactly one cycle. The bubble clears IDEX_Ctrl.MemRead, so hazard deasserts on the next cycle.
- Back-to-back dependent loads each stall once.
- Rs or Rt equal to $0 never triggers a stall.
- MemStall during a pending hazard: the hold takes precedence, and the hazard is re-evaluated after MemStall drops. The result is still exactly one bubble.
- Reset mid-stall: outputs go to 0 immediately, with no residual stall.
- All register-capture logic is edge-triggered. Outputs are driven only from flops, except PCWrite and IFID_Write.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- When defined:
  - Adds output StallCount [15:0], reset to 0.
  - Increments by 1 on each edge where a hazard bubble is inserted (not on Flush, not on MemStall).
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - control-bit index constants (CTRL_REGWRITE ... CTRL_ALUOP_LSB)
  - CTRL_W = 9
  - ALUOp encodings
  - BUBBLE_CTRL = 0
- One combinational sub-module, load_use_detect, computes hazard. It is reused by the later branch-compare hazard logic.

Test Plan:
- Reset test: assert reset with random inputs, then release -> all IDEX outputs 0, PCWrite = 1, IFID_Write = 1.
- Load-use stall:
  - Stimulus: lw $8 captured (MemRead = 1, Rt = 8), then ID_Rs = 8, ID_Valid = 1.
  - Response: one cycle with PCWrite = 0, IFID_Write = 0 and a bubble in IDEX. Next cycle captures the add with IDEX_Rs = 8.
  - With IDEX_STALL_CNT_EN: StallCount = 1.
- $0 dependency: lw $0 followed by a reader of $0 -> no stall, PCWrite stays 1.
- Flush vs hazard: Flush = 1 in the same cycle as a load-use hazard -> bubble, PCWrite = 1, IFID_Write = 1, StallCount unchanged.
- MemStall hold:
  - Stimulus: captured add $3 (Rs = 1, Rt = 2, Rd = 3), then MemStall high for 3 cycles.
  - Response: IDEX outputs unchanged for those 3 cycles, PCWrite = 0 throughout.
- Counter saturation (macro on): force 65 540 hazard cycles -> StallCount stops at 16'hFFFF.
